// File: rtl/aud_pkg.sv
// Shared definitions for the stereo audio player.
//   MODE_I2S / MODE_LJ : serial framing selectors for the MODE parameter
//   aud_state_e        : serializer FSM state encoding
package aud_pkg;

  localparam int MODE_I2S = 0;
  localparam int MODE_LJ  = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_SHIFT = 2'd2,
    S_PAD   = 2'd3
  } aud_state_e;

endpackage

// File: rtl/aud_lrck_edge.sv
// LRCK edge detector: registers the codec frame clock and flags its edges.
// Ports:
//   i_bclk     : bit clock, rising edge
//   i_rst_n    : asynchronous active-low reset
//   i_daclrck  : frame clock, synchronous to i_bclk (low = left)
//   o_rise     : i_daclrck high while its registered copy is low (right-start)
//   o_fall     : i_daclrck low while its registered copy is high (left-start)
module aud_lrck_edge (
  input  logic i_bclk,
  input  logic i_rst_n,
  input  logic i_daclrck,
  output logic o_rise,
  output logic o_fall
);

  logic lrck_q;

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) lrck_q <= 1'b0;
    else          lrck_q <= i_daclrck;
  end

  assign o_rise =  i_daclrck & ~lrck_q;
  assign o_fall = ~i_daclrck &  lrck_q;

endmodule

// File: rtl/aud_stereo_player.sv
// Stereo I2S / left-justified DAC serializer with a one-pair holding register.
// Ports:
//   i_bclk        : bit clock, the only clock
//   i_rst_n       : asynchronous active-low reset
//   i_daclrck     : codec frame clock (low = left, high = right)
//   i_en          : playback enable
//   i_valid       : i_left/i_right hold a valid pair
//   i_left        : left sample, DATA_W bits
//   i_right       : right sample, DATA_W bits
//   o_ready       : holding register empty, a pair can be accepted
//   o_aud_dacdat  : registered serial data, MSB first
//   o_underrun    : one-cycle pulse when a left-start finds no pair waiting
//
// state   | meaning
// S_IDLE  | disabled or waiting for the first left-start
// S_DELAY | I2S only: one quiet BCLK between the LRCK edge and the MSB
// S_SHIFT | shifting the word out, cnt = bits still to send
// S_PAD   | word done, drive zeros until the next LRCK edge
module aud_stereo_player
  import aud_pkg::*;
#(
  parameter int DATA_W          = 16,
  parameter int MODE            = 0,
  parameter int UNDERRUN_REPEAT = 0
) (
  input  logic              i_bclk,
  input  logic              i_rst_n,
  input  logic              i_daclrck,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_aud_dacdat,
  output logic              o_underrun
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              lrck_rise;
  logic              lrck_fall;
  logic              left_start;
  logic              right_start;
  logic              hold_full;
  aud_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] shreg;
  logic              dat_q;
  logic              und_q;
  logic              ready_q;
  logic [DATA_W-1:0] hold_l;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] right_q;
  logic [DATA_W-1:0] last_l;
  logic [DATA_W-1:0] last_r;
  logic [DATA_W-1:0] left_word;
  logic [DATA_W-1:0] right_word;
  logic [DATA_W-1:0] load_word;

  aud_lrck_edge u_lrck_edge (
    .i_bclk    (i_bclk),
    .i_rst_n   (i_rst_n),
    .i_daclrck (i_daclrck),
    .o_rise    (lrck_rise),
    .o_fall    (lrck_fall)
  );

  // A right-start only means something once a frame has begun on the left.
  assign left_start  = i_en & lrck_fall;
  assign right_start = i_en & lrck_rise & (state != S_IDLE);
  assign hold_full   = ~ready_q;

  always_comb begin
    left_word  = '0;
    right_word = '0;
    if (hold_full) begin
      left_word  = hold_l;
      right_word = hold_r;
    end else if (UNDERRUN_REPEAT != 0) begin
      left_word  = last_l;
      right_word = last_r;
    end
    load_word = left_start ? left_word : right_q;
  end

  // Serializer FSM. Any LRCK edge restarts the word, which also truncates
  // a word that is still shifting when the half-frame is too short.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shreg   <= '0;
      dat_q   <= 1'b0;
      und_q   <= 1'b0;
      right_q <= '0;
      last_l  <= '0;
      last_r  <= '0;
    end else begin
      und_q <= left_start & hold_full ? 1'b0 : left_start;
      if (!i_en) begin
        state <= S_IDLE;
        dat_q <= 1'b0;
      end else if (left_start || right_start) begin
        if (MODE == MODE_LJ) begin
          dat_q <= load_word[DATA_W-1];
          shreg <= {load_word[DATA_W-2:0], 1'b0};
          cnt   <= CNT_W'(DATA_W - 1);
          state <= S_SHIFT;
        end else begin
          dat_q <= 1'b0;
          shreg <= load_word;
          state <= S_DELAY;
        end
      end else begin
        case (state)
          S_IDLE: dat_q <= 1'b0;
          S_DELAY: begin
            dat_q <= shreg[DATA_W-1];
            shreg <= {shreg[DATA_W-2:0], 1'b0};
            cnt   <= CNT_W'(DATA_W - 1);
            state <= S_SHIFT;
          end
          S_SHIFT: begin
            if (cnt == '0) begin
              dat_q <= 1'b0;
              state <= S_PAD;
            end else begin
              dat_q <= shreg[DATA_W-1];
              shreg <= {shreg[DATA_W-2:0], 1'b0};
              cnt   <= cnt - 1'b1;
            end
          end
          S_PAD: dat_q <= 1'b0;
          default: begin
            dat_q <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
      if (left_start) begin
        right_q <= right_word;
        if (hold_full) begin
          last_l <= hold_l;
          last_r <= hold_r;
        end
      end
    end
  end

  // Holding register. A left-start with a full holding register empties it;
  // capture needs o_ready, so the two never coincide.
  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q <= 1'b1;
      hold_l  <= '0;
      hold_r  <= '0;
    end else if (left_start && hold_full) begin
      ready_q <= 1'b1;
    end else if (i_valid && ready_q) begin
      hold_l  <= i_left;
      hold_r  <= i_right;
      ready_q <= 1'b0;
    end
  end

  assign o_aud_dacdat = dat_q;
  assign o_underrun   = und_q;
  assign o_ready      = ready_q;

endmodule
